// File: rtl/ex_mem_buffer_if.sv
// Execute-to-memory pipeline buffer bus: upstream handshake, downstream head entry,
// forwarding taps and occupancy.
interface ex_mem_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 9,
  parameter int unsigned RD_WIDTH   = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_alu_result;
  logic [DATA_WIDTH-1:0] in_store_data;
  logic [PC_WIDTH-1:0]   in_pc;
  logic [RD_WIDTH-1:0]   in_rd;
  logic [2:0]            in_funct3;
  logic                  in_reg_write;
  logic                  in_mem_read;
  logic                  in_mem_write;
  logic                  in_mem_to_reg;
  logic                  flush;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_alu_result;
  logic [DATA_WIDTH-1:0] out_store_data;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [RD_WIDTH-1:0]   out_rd;
  logic [2:0]            out_funct3;
  logic                  out_reg_write;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_mem_to_reg;

  logic                  fwd_en;
  logic [RD_WIDTH-1:0]   fwd_rd;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [1:0]            occupancy;

  modport master (
    output in_valid, in_alu_result, in_store_data, in_pc, in_rd, in_funct3,
           in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_store_data, out_pc, out_rd, out_funct3,
           out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
           fwd_en, fwd_rd, fwd_data, occupancy
  );

  modport slave (
    input  in_valid, in_alu_result, in_store_data, in_pc, in_rd, in_funct3,
           in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_store_data, out_pc, out_rd, out_funct3,
           out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
           fwd_en, fwd_rd, fwd_data, occupancy
  );
endinterface

// File: rtl/ex_mem_buffer.sv
// Two-entry EX/MEM skid buffer: head register drives the memory stage, skid register absorbs
// one extra entry so in_ready can be registered.
module ex_mem_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 9,
  parameter int unsigned RD_WIDTH   = 5
) (
  input logic              clk,
  input logic              rst_n,
  ex_mem_buffer_if.slave   bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] store_data;
    logic [PC_WIDTH-1:0]   pc;
    logic [RD_WIDTH-1:0]   rd;
    logic [2:0]            funct3;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_ready_q;
  logic   out_valid;
  logic   accept;
  logic   emit;

  // Capture-time cleanup: writes to x0 are dropped, a store overrides a read.
  always_comb begin
    in_entry            = '0;
    in_entry.alu_result = bus.in_alu_result;
    in_entry.store_data = bus.in_store_data;
    in_entry.pc         = bus.in_pc;
    in_entry.rd         = bus.in_rd;
    in_entry.funct3     = bus.in_funct3;
    in_entry.reg_write  = bus.in_reg_write & (bus.in_rd != '0);
    in_entry.mem_read   = bus.in_mem_read & ~bus.in_mem_write;
    in_entry.mem_write  = bus.in_mem_write;
    in_entry.mem_to_reg = bus.in_mem_to_reg;
  end

  assign out_valid = (state_q != StEmpty);
  assign accept    = bus.in_valid & in_ready_q;
  assign emit      = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && emit) begin
            head_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = StFull;
          end else if (emit) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (emit) begin
            head_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_alu_result = head_q.alu_result;
  assign bus.out_store_data = head_q.store_data;
  assign bus.out_pc         = head_q.pc;
  assign bus.out_rd         = head_q.rd;
  assign bus.out_funct3     = head_q.funct3;
  assign bus.out_reg_write  = head_q.reg_write;
  assign bus.out_mem_read   = head_q.mem_read;
  assign bus.out_mem_write  = head_q.mem_write;
  assign bus.out_mem_to_reg = head_q.mem_to_reg;

  // A load result is not ready until the memory stage returns it.
  assign bus.fwd_en   = out_valid & head_q.reg_write & ~head_q.mem_read;
  assign bus.fwd_rd   = head_q.rd;
  assign bus.fwd_data = head_q.alu_result;

  always_comb begin
    bus.occupancy = 2'd0;
    unique case (state_q)
      StEmpty: bus.occupancy = 2'd0;
      StOne:   bus.occupancy = 2'd1;
      StFull:  bus.occupancy = 2'd2;
      default: bus.occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Scoreboard bench for ex_mem_buffer: a FIFO model of at most two entries predicts the
// head, status and forwarding outputs; emitted entries are popped and compared in order.
module tb_ex_mem_buffer;
  localparam int DW = 32;
  localparam int PW = 9;
  localparam int RW = 5;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
    logic [PW-1:0] pc;
    logic [RW-1:0] rd;
    logic [2:0]    f3;
    logic          rw;
    logic          mr;
    logic          mw;
    logic          m2r;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   started = 1'b0;
  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t idle = '0;

  always #5 clk = ~clk;

  ex_mem_buffer_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .RD_WIDTH(RW)) bus ();

  ex_mem_buffer #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .RD_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t out_ent();
    return {bus.out_alu_result, bus.out_store_data, bus.out_pc, bus.out_rd, bus.out_funct3,
            bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg};
  endfunction

  // What the buffer should store for a given input.
  function automatic ent_t canon(input ent_t e);
    ent_t r = e;
    r.rw = e.rw && (e.rd != 0);
    r.mr = e.mr && !e.mw;
    return r;
  endfunction

  function automatic ent_t mk(input logic [31:0] a, input logic [4:0] r, input logic rw,
                              input logic mr);
    ent_t e = '0;
    e.alu = a;
    e.sd  = a ^ 32'h5A5A_5A5A;
    e.pc  = 9'h1F0;
    e.rd  = r;
    e.f3  = 3'd2;
    e.rw  = rw;
    e.mr  = mr;
    e.m2r = mr;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.alu = $urandom();
    e.sd  = $urandom();
    e.pc  = PW'($urandom());
    e.rd  = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom());
    e.f3  = 3'($urandom());
    e.rw  = 1'($urandom());
    e.mr  = 1'($urandom());
    e.mw  = 1'($urandom());
    e.m2r = 1'($urandom());
    return e;
  endfunction

  task automatic drive(input logic v, input ent_t e, input logic ordy, input logic fl);
    bus.in_valid      = v;
    bus.in_alu_result = e.alu;
    bus.in_store_data = e.sd;
    bus.in_pc         = e.pc;
    bus.in_rd         = e.rd;
    bus.in_funct3     = e.f3;
    bus.in_reg_write  = e.rw;
    bus.in_mem_read   = e.mr;
    bus.in_mem_write  = e.mw;
    bus.in_mem_to_reg = e.m2r;
    bus.out_ready     = ordy;
    bus.flush         = fl;
  endtask

  // Called 2 time units after a rising edge; returns 2 units after the next one.
  task automatic step(input logic v, input ent_t e, input logic ordy, input logic fl);
    drive(v, e, ordy, fl);
    if (!rst_n || fl) exp_q.delete();
    else if (v && exp_q.size() < 2) exp_q.push_back(canon(e));
    @(posedge clk);
    #2;
  endtask

  // Status and head check just after each edge.
  always @(posedge clk) begin
    #1;
    if (started) begin
      if (!rst_n) begin
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_fwd_en", bus.fwd_en, 0);
        chk("rst_fields", out_ent(), 0);
      end else begin
        chk("occupancy", bus.occupancy, exp_q.size());
        chk("in_ready", bus.in_ready, exp_q.size() < 2);
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("head", out_ent(), exp_q[0]);
          chk("fwd_en", bus.fwd_en, exp_q[0].rw && !exp_q[0].mr);
          chk("fwd_rd", bus.fwd_rd, exp_q[0].rd);
          chk("fwd_data", bus.fwd_data, exp_q[0].alu);
        end else begin
          chk("fwd_en_empty", bus.fwd_en, 0);
        end
      end
    end
  end

  // Consumed entries must come out in acceptance order.
  always @(negedge clk) begin
    ent_t e;
    if (started && rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL emit: got unexpected entry %0h expected none", out_ent());
      end else begin
        e = exp_q.pop_front();
        chk("emit", out_ent(), e);
      end
    end
  end

  initial begin
    drive(0, idle, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    started = 1'b1;
    step(0, idle, 0, 0);
    rst_n = 1'b1;
    step(0, idle, 1, 0);

    // Pass-through
    step(1, mk(32'h0000_0010, 5, 1, 0), 1, 0);
    chk("pt_valid", bus.out_valid, 1);
    chk("pt_alu", bus.out_alu_result, 32'h10);
    chk("pt_fwd_en", bus.fwd_en, 1);
    chk("pt_fwd_rd", bus.fwd_rd, 5);
    chk("pt_occ", bus.occupancy, 1);
    step(0, idle, 1, 0);

    // Write to x0
    step(1, mk(32'hDEAD_BEEF, 0, 1, 0), 1, 0);
    chk("rd0_rw", bus.out_reg_write, 0);
    chk("rd0_fwd_en", bus.fwd_en, 0);
    chk("rd0_alu", bus.out_alu_result, 32'hDEAD_BEEF);
    step(0, idle, 1, 0);

    // Load is not forwardable
    step(1, mk(32'h0000_0400, 7, 1, 1), 1, 0);
    chk("ld_valid", bus.out_valid, 1);
    chk("ld_fwd_en", bus.fwd_en, 0);
    step(0, idle, 1, 0);

    // Backpressure
    step(1, mk(32'hAAAA_0001, 1, 1, 0), 0, 0);
    step(1, mk(32'hBBBB_0002, 2, 1, 0), 0, 0);
    chk("bp_occ", bus.occupancy, 2);
    chk("bp_ready", bus.in_ready, 0);
    chk("bp_head", bus.out_alu_result, 32'hAAAA_0001);
    step(1, mk(32'hCCCC_0003, 3, 1, 0), 0, 0);
    chk("bp_head_stable", bus.out_alu_result, 32'hAAAA_0001);
    step(0, idle, 1, 0);
    chk("bp_second", bus.out_alu_result, 32'hBBBB_0002);
    step(0, idle, 1, 0);
    chk("bp_drained", bus.out_valid, 0);
    chk("bp_ready_back", bus.in_ready, 1);

    // Flush while full with a valid input
    step(1, mk(32'h1111_0001, 4, 1, 0), 0, 0);
    step(1, mk(32'h2222_0002, 6, 1, 0), 0, 0);
    step(1, mk(32'h3333_0003, 8, 1, 0), 0, 1);
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_occ", bus.occupancy, 0);
    chk("fl_ready", bus.in_ready, 1);
    chk("fl_fwd_en", bus.fwd_en, 0);
    repeat (3) step(0, idle, 1, 0);

    // Reset while full
    step(1, mk(32'h4444_0001, 9, 1, 0), 0, 0);
    step(1, mk(32'h5555_0002, 10, 1, 0), 0, 0);
    rst_n = 1'b0;
    step(1, mk(32'h6666_0003, 11, 1, 0), 1, 0);
    chk("rr_valid", bus.out_valid, 0);
    chk("rr_fields", out_ent(), 0);
    chk("rr_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    step(0, idle, 1, 0);
    chk("rr_ready_after", bus.in_ready, 1);
    repeat (3) step(0, idle, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic v, fl, ordy;
      v    = ($urandom_range(0, 99) < 70);
      fl   = ($urandom_range(0, 99) < 3);
      ordy = fl ? 1'b0 : ($urandom_range(0, 99) < 60);
      step(v, rnd_ent(), ordy, fl);
    end

    repeat (4) step(0, idle, 1, 0);
    chk("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_buffer.md
EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the ALU result and store-data width.
REQ-002 SHALL have parameter PC_WIDTH, default 9, the PC width, matching PC_Cur.
REQ-003 SHALL have parameter RD_WIDTH, default 5, the destination register index width.
REQ-004 SHALL have one clock and a synchronous active-low reset, with these ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have these upstream (execute side) ports:
- in_valid  in  1  execute-stage entry valid.
- in_ready  out  1  buffer can accept; registered.
- in_alu_result  in  DATA_WIDTH  ALUResult from the ALU.
- in_store_data  in  DATA_WIDTH  rs2 value for stores.
- in_pc  in  PC_WIDTH  PC of the instruction.
- in_rd  in  RD_WIDTH  destination register index.
- in_funct3  in  3  memory access size/sign.
- in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg  in  1 each  control bits.
- flush  in  1  discard all held and incoming entries.
REQ-006 SHALL have these downstream (memory side) ports:
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage consumes head.
- out_alu_result, out_store_data, out_pc, out_rd, out_funct3, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out  matching widths  head entry fields.
REQ-007 SHALL have these status and forwarding ports:
- fwd_en  out  1  head result forwardable to execute.
- fwd_rd  out  RD_WIDTH  head destination index.
- fwd_data  out  DATA_WIDTH  head ALU result.
- occupancy  out  2  entries held, 0..2.

Function
REQ-008 SHALL hold two entries: a head register driving the out_* ports and a skid register.
REQ-009 SHALL implement the FSM EMPTY (0 entries), ONE (head only) and FULL (head and skid); occupancy SHALL equal 0, 1, 2 respectively.
REQ-010 SHALL define accept = in_valid & in_ready and emit = out_valid & out_ready, both evaluated at the same rising edge.
REQ-011 SHALL make these transitions:
- EMPTY: accept -> head<=input, ONE.
- ONE: accept & !emit -> skid<=input, FULL.
- ONE: accept & emit -> head<=input, stay ONE.
- ONE: !accept & emit -> EMPTY.
- ONE: otherwise -> hold.
- FULL: emit -> head<=skid, ONE.
- FULL: otherwise -> hold.
REQ-012 SHALL keep in_ready registered, equal to 1 in EMPTY and ONE and 0 in FULL; FULL plus in_valid SHALL NOT drop or overwrite data.
REQ-013 SHALL have latency 1: an entry accepted at edge N appears on out_* after edge N when the buffer was EMPTY, or when ONE with a same-edge emit.
REQ-014 SHALL set out_valid = (state != EMPTY), and head fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-015 SHALL deliver entries in acceptance order, with no duplication or loss.
REQ-016 SHALL force the stored reg_write to 0 at capture when in_rd == 0.
REQ-017 SHALL take mem_write and mem_read as given; if both are 1, mem_write wins and the stored mem_read is 0.
REQ-018 SHALL drive fwd_en = out_valid & out_reg_write & !out_mem_read, fwd_rd = out_rd and fwd_data = out_alu_result, all combinational from the head.
REQ-019 SHALL give flush priority over accept and emit: next state EMPTY, the incoming entry discarded, in_ready=1 next cycle; data registers may hold stale values but out_valid and fwd_en SHALL be 0.
REQ-020 SHALL pass all data fields bit-exact, with no arithmetic, sign change or truncation.

Reset
REQ-021 SHALL, while rst_n=0 at a rising edge, enter EMPTY, clear every out_* data and control field, and drive out_valid=0, fwd_en=0 and occupancy=0.
REQ-022 SHALL hold in_ready at 0 during reset and at 1 from the first edge with rst_n=1.
REQ-023 SHALL discard both entries when reset is asserted mid-operation (FULL), with no entry emitted afterwards.

Verification
REQ-024 Pass-through: out_ready=1, accept result 0x0000_0010 / rd=5 / reg_write=1 -> next cycle out_valid=1, out_alu_result=0x10, fwd_en=1, fwd_rd=5, occupancy=1.
REQ-025 Backpressure: out_ready=0, accept A=0xAAAA_0001 then B=0xBBBB_0002 -> occupancy=2, in_ready=0, head=A stable; raise out_ready -> A then B emitted on consecutive cycles, then in_ready=1.
REQ-026 Flush while FULL with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1; the flushed inputs never appear.
REQ-027 rd=0 with reg_write=1 and result 0xDEAD_BEEF -> out_reg_write=0, fwd_en=0, out_alu_result=0xDEAD_BEEF.
REQ-028 Load: mem_read=1, reg_write=1, rd=7 -> out_valid=1, fwd_en=0.
REQ-029 Reset in FULL: rst_n=0 for one edge -> all outputs 0; after release in_ready=1 and no stale entry is emitted.
